// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, functs,
// ALU codes, datapath select codes and controller state codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUREG = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUREG = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_BRANCH = 2'b11;

    localparam logic [3:0] S_INIT     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_WB_LW    = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_EXE_R    = 4'd7;
    localparam logic [3:0] S_WB_R     = 4'd8;
    localparam logic [3:0] S_EXE_I    = 4'd9;
    localparam logic [3:0] S_WB_I     = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_JAL      = 4'd13;
    localparam logic [3:0] S_HALT     = 4'd15;

    // What the ALU is being used for in the current state.
    typedef enum logic [2:0] {
        ALU_CLS_NONE,
        ALU_CLS_ADD,
        ALU_CLS_SUB,
        ALU_CLS_RTYPE,
        ALU_CLS_ITYPE
    } alu_class_e;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALU usage class plus opcode/funct to the ALU
// operation code, the immediate-extension mode and a funct legality flag.
module alu_decoder
    import mips_pkg::*;
(
    input  alu_class_e  alu_class_i,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    output logic [3:0]  alu_ctrl_o,
    output logic        imm_zext_o,
    output logic        funct_valid_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves a signal unassigned, which would infer a latch.
        alu_ctrl_o    = ALU_AND;
        imm_zext_o    = 1'b0;
        funct_valid_o = 1'b1;
        case (alu_class_i)
            ALU_CLS_ADD: alu_ctrl_o = ALU_ADD;
            ALU_CLS_SUB: alu_ctrl_o = ALU_SUB;
            ALU_CLS_RTYPE: begin
                case (funct_i)
                    FN_ADD:  alu_ctrl_o = ALU_ADD;
                    FN_SUB:  alu_ctrl_o = ALU_SUB;
                    FN_AND:  alu_ctrl_o = ALU_AND;
                    FN_OR:   alu_ctrl_o = ALU_OR;
                    FN_SLT:  alu_ctrl_o = ALU_SLT;
                    default: funct_valid_o = 1'b0;
                endcase
            end
            ALU_CLS_ITYPE: begin
                case (opcode_i)
                    OP_ADDI: alu_ctrl_o = ALU_ADD;
                    OP_SLTI: alu_ctrl_o = ALU_SLT;
                    OP_ANDI: begin
                        alu_ctrl_o = ALU_AND;
                        imm_zext_o = 1'b1;
                    end
                    OP_ORI: begin
                        alu_ctrl_o = ALU_OR;
                        imm_zext_o = 1'b1;
                    end
                    default: alu_ctrl_o = ALU_AND;
                endcase
            end
            default: alu_ctrl_o = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch, decode,
// execute, memory and write-back and drives every datapath enable and select.
module multicycle_ctrl
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        iord,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        imm_zext,
    output logic [3:0]  alu_ctrl,
    output logic        retire,
    output logic        halt,
    output logic [3:0]  state
);

    logic [3:0]  state_q, state_d;
    alu_class_e  alu_class;
    logic        funct_valid;

    alu_decoder u_alu_decoder (
        .alu_class_i   (alu_class),
        .opcode_i      (opcode),
        .funct_i       (funct),
        .alu_ctrl_o    (alu_ctrl),
        .imm_zext_o    (imm_zext),
        .funct_valid_o (funct_valid)
    );

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d    = state_q;
        pc_we      = 1'b0;
        pc_src     = PC_SRC_ALU;
        iord       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = REG_DST_RT;
        mem_to_reg = M2R_ALUREG;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        retire     = 1'b0;
        halt       = 1'b0;
        alu_class  = ALU_CLS_NONE;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                alu_class = ALU_CLS_ADD;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // PC + (imm << 2) lands in alu_reg for a possible branch.
                alu_src_b = SRC_B_BRANCH;
                alu_class = ALU_CLS_ADD;
                case (opcode)
                    OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                    OP_RTYPE:                         state_d = S_EXE_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXE_I;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_J:                             state_d = S_JUMP;
                    OP_JAL:                           state_d = S_JAL;
                    default:                          state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                alu_class = ALU_CLS_ADD;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_WB_LW;
            end
            S_WB_LW: begin
                reg_we     = 1'b1;
                reg_dst    = REG_DST_RT;
                mem_to_reg = M2R_MDR;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXE_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_REG;
                alu_class = ALU_CLS_RTYPE;
                state_d   = funct_valid ? S_WB_R : S_HALT;
            end
            S_WB_R: begin
                reg_we     = 1'b1;
                reg_dst    = REG_DST_RD;
                mem_to_reg = M2R_ALUREG;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXE_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                alu_class = ALU_CLS_ITYPE;
                state_d   = S_WB_I;
            end
            S_WB_I: begin
                reg_we     = 1'b1;
                reg_dst    = REG_DST_RT;
                mem_to_reg = M2R_ALUREG;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_REG;
                alu_class = ALU_CLS_SUB;
                pc_src    = PC_SRC_ALUREG;
                pc_we     = (opcode == OP_BNE) ? !zero : zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = PC_SRC_JUMP;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                // The register file captures PC (already PC+4) as the PC loads.
                pc_src     = PC_SRC_JUMP;
                pc_we      = 1'b1;
                reg_we     = 1'b1;
                reg_dst    = REG_DST_RA;
                mem_to_reg = M2R_PC;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halt = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle MIPS core. It sequences PC, IR, register file, ALU, ALU output register and memory port through fetch, decode, execute, memory and write-back. Every datapath enable and mux select is issued from here. Instructions decoded: add, sub, and, or, slt, addi, andi, ori, slti, lw, sw, beq, bne, j, jal.

## Interface
- No parameters. Opcodes, functs, ALU codes and state codes are fixed constants from the shared package.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26], held stable by IR between ir_we pulses
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational from current-cycle ALU result
- mem_ready  in  1  memory completes the pending access this cycle
- pc_we  out  1  PC load enable
- pc_src  out  2  00 ALU result, 01 alu_reg, 10 jump target {PC[31:28],IR[25:0],2'b00}
- iord  out  1  memory address: 0 PC, 1 alu_reg
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier for mem_req
- ir_we  out  1  IR load enable
- reg_we  out  1  register-file write enable
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 alu_reg, 01 MDR, 10 PC
- alu_src_a  out  1  0 PC, 1 A register
- alu_src_b  out  2  00 B register, 01 constant 4, 10 extended imm, 11 sign-ext imm<<2
- imm_zext  out  1  1 zero-extend imm (andi, ori), 0 sign-extend
- alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- retire  out  1  one-cycle pulse in the final cycle of each completed instruction
- halt  out  1  high while in HALT
- state  out  4  current state code, for debug

## Operation
- State register is clocked. Outputs are a combinational decode of state plus opcode/funct/zero/mem_ready.
- Every output is 0 unless listed for the current state.
- alu_reg latches the ALU result every cycle without an enable. The value computed in cycle N is therefore available as alu_reg in cycle N+1.
- INIT (0): all outputs 0. Next state: FETCH.
- FETCH (1): mem_req, iord=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00. ir_we=pc_we=mem_ready. Stays in FETCH while !mem_ready; otherwise goes to DECODE.
- DECODE (2): alu_src_a=0, alu_src_b=11, ADD; this precomputes the branch target into alu_reg. Next state by opcode:
  - lw/sw: MEM_ADDR
  - R-type: EXE_R
  - addi/andi/ori/slti: EXE_I
  - beq/bne: BRANCH
  - j: JUMP
  - jal: JAL
  - any other opcode: HALT
- MEM_ADDR (3): alu_src_a=1, alu_src_b=10, ADD. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD (4): mem_req, iord=1. Stays while !mem_ready; otherwise goes to WB_LW.
- WB_LW (5): reg_we, reg_dst=00, mem_to_reg=01, retire. Next: FETCH.
- MEM_WR (6): mem_req, mem_we, iord=1. Stays while !mem_ready; when mem_ready, asserts retire and goes to FETCH.
- EXE_R (7): alu_src_a=1, alu_src_b=00.
  - funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - Unknown funct: alu_ctrl=0000, next state HALT. Otherwise next state WB_R.
- WB_R (8): reg_we, reg_dst=01, mem_to_reg=00, retire. Next: FETCH.
- EXE_I (9): alu_src_a=1, alu_src_b=10.
  - addi: ADD; slti: SLT; andi: AND with imm_zext; ori: OR with imm_zext.
  - Next: WB_I.
- WB_I (10): reg_we, reg_dst=00, mem_to_reg=00, retire. Next: FETCH.
- BRANCH (11): alu_src_a=1, alu_src_b=00, SUB, pc_src=01, retire. pc_we=zero for beq, !zero for bne. Next: FETCH.
- JUMP (12): pc_src=10, pc_we, retire. Next: FETCH.
- JAL (13): pc_src=10, pc_we, reg_we, reg_dst=10, mem_to_reg=10, retire. The register file captures the pre-update PC (already PC+4) on the same edge the PC loads. Next: FETCH.
- HALT (15): halt=1, all other outputs 0. Exits only on rst.
- Code 14 is unused and must decode to INIT.

## Timing
- rst asserted: state=INIT immediately (asynchronous), all outputs 0 including halt and retire. First FETCH is the cycle after rst deasserts.
- Latency with zero wait states:
  - R-type, I-type arithmetic: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne, j, jal: 3 cycles
- Each mem_ready-low cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- mem_req and iord stay constant for the whole of a wait period.
- mem_ready is ignored in all states except FETCH, MEM_RD and MEM_WR.
- rst mid-instruction (for example during MEM_WR): the access is abandoned, mem_req drops asynchronously, no write-back occurs.

## Structure
- Package mips_pkg holds: opcode and funct constants, ALU code constants, pc_src/reg_dst/mem_to_reg/alu_src_b select codes, and 4-bit state codes.
- Sub-module alu_decoder: combinational map from (state class, opcode, funct) to {alu_ctrl, imm_zext, funct_valid}. It is instantiated once.

## Test plan
- Reset: hold rst high for 3 cycles -> state=0, all outputs 0; after release, FETCH follows INIT by one cycle.
- add (opcode 000000, funct 100000), mem_ready=1 -> states 1,2,7,8; alu_ctrl=0010 in state 7; in state 8 reg_we=1, reg_dst=01, retire=1; next state 1.
- lw with mem_ready low for 2 cycles in MEM_RD -> iord=1 and mem_req=1 held for 3 cycles; WB_LW asserts mem_to_reg=01; total 7 cycles.
- beq with zero=1, then with zero=0 -> pc_we=1/pc_src=01, then pc_we=0; retire=1 in both cases; 3 cycles each.
- Opcode 111111, then R-type with funct 000000 -> HALT after DECODE, and after EXE_R, respectively; halt=1 held for 10 cycles; rst returns state to INIT.
- rst asserted in MEM_WR during a wait -> mem_we and mem_req drop within the same cycle; no retire pulse.
